sysid_checker: RTL and testbench
================================

# sysid_checker

Avalon-MM master that reads the system ID peripheral after reset (or on request) and checks both words against build-time constants. Issues a read of word 0 (system ID), then word 1 (build timestamp), captures the returned data, and reports per-word match flags, a done flag and a timeout flag. Sits directly upstream of the system ID slave on the interconnect. Its status outputs feed the boot/status logic, which gates on a valid hardware build.

## Interface
- EXPECTED_ID, default 32'd0: required value of word 0
- EXPECTED_TS, default 32'd1616605598: required value of word 1
- TIMEOUT_CYCLES, default 255: maximum cycles allowed per read transaction; legal range ≥ 2

Ports:
- clock  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run or re-run the check
- avm_address  out  1  word address (0 = ID, 1 = timestamp)
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  check in progress
- done  out  1  check finished; level, held until next run
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TS
- timeout  out  1  a transaction exceeded TIMEOUT_CYCLES
- id_value  out  32  captured word 0
- ts_value  out  32  captured word 1

## Operation
- FSM states: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE.
- Reset values: state IDLE. avm_read, busy, done, id_ok, ts_ok and timeout are 0. avm_address, id_value and ts_value are 0. Reset is asynchronous and aborts any transaction immediately.
- Entry from IDLE or DONE:
  - Triggered by start=1 or by the autostart condition (see Configuration).
  - Clears done, id_ok, ts_ok, timeout, id_value and ts_value, then enters REQ_ID.
- start during REQ_* or WAIT_* is ignored.
- REQ_ID and REQ_TS:
  - avm_read=1; avm_address=0 or 1 respectively.
  - avm_address is held stable while avm_waitrequest=1.
  - A cycle with avm_read=1 and avm_waitrequest=0 accepts the read; the FSM moves to the matching WAIT state.
  - avm_readdatavalid is ignored in REQ states.
- WAIT_ID and WAIT_TS:
  - avm_read=0.
  - On avm_readdatavalid=1, capture avm_readdata into id_value or ts_value. Set id_ok or ts_ok by 32-bit equality compare on the captured data.
  - WAIT_ID advances to REQ_TS; WAIT_TS advances to DONE.
- DONE: busy=0, done=1. Stays in DONE until a new trigger.
- busy=1 in every REQ_* and WAIT_* state.
- Timeout:
  - The per-transaction counter is $clog2(TIMEOUT_CYCLES+1) bits wide. It clears on entering each REQ state and increments every cycle in REQ and WAIT states.
  - If the transaction has not completed by the cycle where the count equals TIMEOUT_CYCLES-1, the FSM goes to DONE with timeout=1 and avm_read is dropped.
  - Flags for words not yet captured stay 0.
  - readdatavalid arriving on that same cycle wins: data is captured and no timeout is raised.

## Timing
- Zero-wait slave with readdatavalid one cycle after acceptance: the FSM leaves IDLE at edge 0, and done=1 and busy=0 are visible after edge 4.
- Each waitrequest cycle adds one cycle. Each extra cycle of read latency adds one cycle.
- id_ok and id_value update on the edge after readdatavalid in WAIT_ID. ts_ok and ts_value update on the edge after readdatavalid in WAIT_TS.
- At most one outstanding read at any time.

## Configuration
- SYSID_CHECK_AUTOSTART_EN defined: one-shot autostart. The first clock edge in IDLE after reset deassertion behaves as start=1, so the check runs once per reset with no software action.
- Undefined: the FSM waits in IDLE for start.

## Test plan
- Autostart, zero-wait slave returning 0 then 1616605598 with one-cycle readdatavalid -> done=1 after edge 4; id_ok=1, ts_ok=1, timeout=0.
- Slave returns 32'h0000_0001 for word 0 -> id_ok=0, ts_ok=1, id_value=1; done=1.
- avm_waitrequest held high for 3 cycles on the word-1 read -> avm_address=1 and avm_read=1 stable for 4 cycles; done 3 cycles later than baseline.
- TIMEOUT_CYCLES=8, slave never asserts readdatavalid for word 1 -> after 8 cycles in REQ_TS/WAIT_TS: timeout=1, done=1, id_ok=1, ts_ok=0, avm_read=0.
- reset_n pulsed low mid-WAIT_ID -> all outputs return to reset values asynchronously. start after release -> full check completes normally.
- start asserted while busy -> ignored. start in DONE -> flags clear next edge and a new check runs.

Source files
------------

// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM master that reads the system ID peripheral
// (word 0 = system ID, word 1 = build timestamp), compares both words
// against build-time constants and reports match, done and timeout status.
//
// Optional feature macro: SYSID_CHECK_AUTOSTART_EN
//   defined   -> the check runs once automatically after every reset
//   undefined -> the check runs only when start is pulsed
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1616605598,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ_ID,
      WAIT_ID,
      REQ_TS,
      WAIT_TS,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             trigger;
   logic             in_txn;
   logic             rdv_wait;
   logic             tmo_hit;

`ifdef SYSID_CHECK_AUTOSTART_EN
   logic auto_pend;

   // One-shot autostart: armed by reset, consumed by the first edge in IDLE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         auto_pend <= 1'b1;
      end else if (state == IDLE) begin
         auto_pend <= 1'b0;
      end
   end

   assign trigger = start | auto_pend;
`else
   assign trigger = start;
`endif

   // A read is in flight in any REQ/WAIT state; data arriving in a WAIT
   // state completes the transaction and beats a same-cycle timeout.
   assign in_txn   = (state == REQ_ID) || (state == WAIT_ID) ||
                     (state == REQ_TS) || (state == WAIT_TS);
   assign rdv_wait = ((state == WAIT_ID) || (state == WAIT_TS)) && avm_readdatavalid;
   assign tmo_hit  = in_txn && (cnt == CNT_LAST) && !rdv_wait;

   // Check sequencer: all bus and status outputs are registered here.
   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: every register in this block uses non-blocking assignment so
      // all next-state values are computed from the same pre-edge snapshot.
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         avm_address <= 1'b0;
         avm_read    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout     <= 1'b0;
         id_value    <= 32'd0;
         ts_value    <= 32'd0;
      end else if (tmo_hit) begin
         // Abandon the transaction; flags of uncaptured words stay 0.
         state    <= DONE;
         avm_read <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b1;
         timeout  <= 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (trigger) begin
                  state       <= REQ_ID;
                  cnt         <= '0;
                  avm_address <= 1'b0;
                  avm_read    <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  id_ok       <= 1'b0;
                  ts_ok       <= 1'b0;
                  timeout     <= 1'b0;
                  id_value    <= 32'd0;
                  ts_value    <= 32'd0;
               end
            end

            REQ_ID, REQ_TS: begin
               cnt <= cnt + CNT_W'(1);
               if (!avm_waitrequest) begin
                  avm_read <= 1'b0;
                  state    <= (state == REQ_ID) ? WAIT_ID : WAIT_TS;
               end
            end

            WAIT_ID: begin
               if (avm_readdatavalid) begin
                  id_value    <= avm_readdata;
                  id_ok       <= (avm_readdata == EXPECTED_ID);
                  state       <= REQ_TS;
                  cnt         <= '0;
                  avm_address <= 1'b1;
                  avm_read    <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            WAIT_TS: begin
               if (avm_readdatavalid) begin
                  ts_value <= avm_readdata;
                  ts_ok    <= (avm_readdata == EXPECTED_TS);
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: directed tests for sysid_checker against a small
// Avalon-MM slave model. Expected results are pushed to a scoreboard when a
// check is launched; a monitor pops and compares on each rising done.
module tb_sysid_checker;

   localparam logic [31:0] EXP_TS = 32'd1616605598;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        busy;
   logic        done;
   logic        id_ok;
   logic        ts_ok;
   logic        timeout;
   logic [31:0] id_value;
   logic [31:0] ts_value;

   typedef struct {
      logic [31:0] id_v;
      logic [31:0] ts_v;
      logic        id_ok;
      logic        ts_ok;
      logic        tmo;
      int          done_edge;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;
   int edge_n   = 0;

   // slave model configuration
   logic [31:0] d0;
   logic [31:0] d1;
   int          wait1;
   bit          drop1;
   int          rd1_cycles;

   sysid_checker #(
      .EXPECTED_ID   (32'd0),
      .EXPECTED_TS   (EXP_TS),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .start            (start),
      .avm_address      (avm_address),
      .avm_read         (avm_read),
      .avm_waitrequest  (avm_waitrequest),
      .avm_readdata     (avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .busy             (busy),
      .done             (done),
      .id_ok            (id_ok),
      .ts_ok            (ts_ok),
      .timeout          (timeout),
      .id_value         (id_value),
      .ts_value         (ts_value)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Slave: waitrequest on word 1 for wait1 cycles, readdatavalid one cycle
   // after acceptance; drop1 suppresses the word-1 response entirely.
   initial begin
      bit pending;
      bit pend_addr;
      int wait_cnt;
      pending = 0; pend_addr = 0; wait_cnt = 0;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
      forever begin
         @(negedge clock);
         avm_readdatavalid = 1'b0;
         if (!reset_n) pending = 0;
         if (pending) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_addr ? d1 : d0;
            pending           = 0;
         end
         if (avm_read) begin
            if (avm_address) rd1_cycles++;
            if (wait_cnt < (avm_address ? wait1 : 0)) begin
               avm_waitrequest = 1'b1;
               wait_cnt++;
            end else begin
               avm_waitrequest = 1'b0;
               wait_cnt        = 0;
               if (!(avm_address && drop1)) begin
                  pending   = 1;
                  pend_addr = avm_address;
               end
            end
         end else begin
            avm_waitrequest = 1'b0;
            wait_cnt        = 0;
         end
      end
   end

   // Monitor: compare final status against the scoreboard on each rising done.
   initial begin
      logic done_prev;
      exp_t e;
      done_prev = 1'b0;
      forever begin
         @(negedge clock);
         if (reset_n && done && !done_prev) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("done_edge", edge_n, e.done_edge);
               check("id_ok",     id_ok,    e.id_ok);
               check("ts_ok",     ts_ok,    e.ts_ok);
               check("timeout",   timeout,  e.tmo);
               check("id_value",  id_value, e.id_v);
               check("ts_value",  ts_value, e.ts_v);
               check("busy_low",  busy,     1'b0);
               check("read_low",  avm_read, 1'b0);
            end
         end
         done_prev = done;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_read"},    avm_read,    1'b0);
      check({tag, "_addr"},    avm_address, 1'b0);
      check({tag, "_busy"},    busy,        1'b0);
      check({tag, "_done"},    done,        1'b0);
      check({tag, "_id_ok"},   id_ok,       1'b0);
      check({tag, "_ts_ok"},   ts_ok,       1'b0);
      check({tag, "_timeout"}, timeout,     1'b0);
      check({tag, "_id_v"},    id_value,    32'd0);
      check({tag, "_ts_v"},    ts_value,    32'd0);
   endtask

   task automatic wait_done(input int max_cycles);
      int i = 0;
      while (!done && i < max_cycles) begin
         @(negedge clock);
         i++;
      end
      check("done_reached", done, 1'b1);
   endtask

   // Configure the slave, push the expectation and pulse start.
   // Baseline: done visible after edge 4 counted from the start edge.
   task automatic launch(input logic [31:0] d0_i, input logic [31:0] d1_i,
                         input int w1, input bit drop,
                         input logic e_id_ok, input logic e_ts_ok, input logic e_tmo,
                         input logic [31:0] e_id_v, input logic [31:0] e_ts_v,
                         input int extra);
      exp_t e;
      @(negedge clock);
      d0 = d0_i; d1 = d1_i; wait1 = w1; drop1 = drop; rd1_cycles = 0;
      e.id_v = e_id_v; e.ts_v = e_ts_v; e.id_ok = e_id_ok; e.ts_ok = e_ts_ok;
      e.tmo = e_tmo; e.done_edge = edge_n + 5 + extra;
      sb.push_back(e);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   initial begin
      start = 1'b0; d0 = 32'd0; d1 = EXP_TS; wait1 = 0; drop1 = 0; rd1_cycles = 0;
      reset_n = 1'b0;
      #3;
      check_reset_outputs("rst");
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      check("idle_no_autostart", busy, 1'b0);

      // Baseline: both words match.
      launch(32'd0, EXP_TS, 0, 0, 1, 1, 0, 32'd0, EXP_TS, 0);
      wait_done(40);

      // Word 0 mismatch.
      launch(32'd1, EXP_TS, 0, 0, 0, 1, 0, 32'd1, EXP_TS, 0);
      wait_done(40);

      // Word 1 mismatch.
      launch(32'd0, EXP_TS + 32'd1, 0, 0, 1, 0, 0, 32'd0, EXP_TS + 32'd1, 0);
      wait_done(40);

      // Three waitrequest cycles on word 1: request held for 4 cycles.
      launch(32'd0, EXP_TS, 3, 0, 1, 1, 0, 32'd0, EXP_TS, 3);
      wait_done(40);
      check("rd1_stable_cycles", rd1_cycles, 32'd4);

      // No readdatavalid for word 1: timeout after 8 cycles in REQ_TS/WAIT_TS.
      launch(32'd0, EXP_TS, 0, 1, 1, 0, 1, 32'd0, 32'd0, 6);
      wait_done(40);

      // Word-1 request stalled forever: timeout drops avm_read.
      launch(32'd0, EXP_TS, 20, 0, 1, 0, 1, 32'd0, 32'd0, 6);
      wait_done(40);
      check("rd1_stalled_cycles", rd1_cycles, 32'd8);

      // readdatavalid on the last counted cycle wins over the timeout.
      launch(32'd5, EXP_TS, 6, 0, 0, 1, 0, 32'd5, EXP_TS, 6);
      wait_done(40);

      // start while busy is ignored: same completion time, one result.
      launch(32'd0, EXP_TS, 0, 0, 1, 1, 0, 32'd0, EXP_TS, 0);
      @(negedge clock);
      check("busy_mid_run", busy, 1'b1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_done(40);
      repeat (3) @(negedge clock);
      check("no_rerun_after_busy_start", busy, 1'b0);

      // start in DONE: flags clear on the next edge, new check runs.
      launch(32'd7, EXP_TS, 0, 0, 0, 1, 0, 32'd7, EXP_TS, 0);
      check("restart_done_clr",  done,     1'b0);
      check("restart_id_ok_clr", id_ok,    1'b0);
      check("restart_ts_ok_clr", ts_ok,    1'b0);
      check("restart_id_v_clr",  id_value, 32'd0);
      check("restart_ts_v_clr",  ts_value, 32'd0);
      check("restart_busy",      busy,     1'b1);
      wait_done(40);

      // Asynchronous reset mid-WAIT_ID, then a normal check.
      @(negedge clock);
      d0 = 32'd0; d1 = EXP_TS; wait1 = 0; drop1 = 0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      check("wait_id_busy", busy, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check("post_rst_idle", busy, 1'b0);
      launch(32'd0, EXP_TS, 0, 0, 1, 1, 0, 32'd0, EXP_TS, 0);
      wait_done(40);

      repeat (3) @(negedge clock);
      check("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
